// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Widest value the negate helper handles; callers zero-extend into it
    // and size-cast the result back down to their own width.
    localparam int MAX_W = 64;

    // Two's-complement negate when n is set, pass-through otherwise.
    // Used both to take operand magnitudes and to sign-fix the product.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                  input logic             n);
        return n ? (~v + {{(MAX_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: multiplicand, accumulator/multiplier shift register, adder.
// Latency: one iteration per cycle while step is high; load takes one cycle.
// Backpressure: none; purely driven by load/step from the controlling FSM.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             capture mcand_in/mplier_in, clear accumulator
//   step             perform one add-and-shift iteration
//   mcand_in         unsigned multiplicand magnitude
//   mplier_in        unsigned multiplier magnitude
//   prod             current {accumulator, multiplier} contents (2*WIDTH bits)
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        // Carry lives in sum[WIDTH]; it is shifted straight into hi, so the
        // {carry, hi, lo} word never needs a separate carry flop.
        sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
        if (load) begin
            mcand_d = mcand_in;
            hi_d    = '0;
            lo_d    = mplier_in;
        end else if (step) begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign prod = {hi_q, lo_q};

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential signed/unsigned WIDTH x WIDTH multiplier with start/busy/done handshake.
// Latency: done pulses WIDTH+1 edges after the accepting edge; one result per WIDTH+2 cycles.
// Backpressure: start is ignored while busy (no queuing); z holds until the next result.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            operation request, sampled only in IDLE
//   signed_mode      1 = two's-complement operands, sampled with start
//   x, y             multiplicand / multiplier, sampled with start
//   busy             high while an operation is in flight
//   done             one-cycle pulse, z valid
//   z                2*WIDTH-bit product, held between operations
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int PW = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               neg_q,   neg_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [PW-1:0]      z_q,     z_d;

    logic               load, step;
    logic [WIDTH-1:0]   abs_x, abs_y;
    logic [PW-1:0]      prod;

    // Magnitudes: the most negative value negates to itself, which read as
    // unsigned is exactly its magnitude, so WIDTH bits always suffice.
    always_comb begin
        abs_x = WIDTH'(cond_neg(MAX_W'(x), signed_mode & x[WIDTH-1]));
        abs_y = WIDTH'(cond_neg(MAX_W'(y), signed_mode & y[WIDTH-1]));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    neg_d   = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Negating a zero magnitude yields zero, so neg needs no masking.
                z_d     = PW'(cond_neg(MAX_W'(prod), neg_q));
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
        end
    end

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .mcand_in  (abs_x),
        .mplier_in (abs_y),
        .prod      (prod)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench: WIDTH=8 and WIDTH=4 instances against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;

    int checks = 0;
    int errors = 0;

    seq_array_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .z(z8)
    );

    seq_array_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .x(x4), .y(y4), .busy(busy4), .done(done4), .z(z4)
    );

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic longint ref_mul(input int w, input bit sm, input longint a, input longint b);
        longint sa, sb, mask;
        sa = a;
        sb = b;
        if (sm && a[w-1]) sa = a - (longint'(1) << w);
        if (sm && b[w-1]) sb = b - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return (sa * sb) & mask;
    endfunction

    // Issue one WIDTH=8 operation, scramble inputs while busy, wait for done.
    // lat = edges after the accepting edge until done is seen (40 = timed out).
    task automatic do_op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] zr, output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; x8 = a; y8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && lat < 40) begin
            x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (busy8) bcnt++;
        end
        zr = z8;
    endtask

    task automatic do_op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] zr, output int lat);
        @(negedge clk);
        start4 = 1'b1; sm4 = sm; x4 = a; y4 = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            x4 = 4'($urandom); y4 = 4'($urandom); sm4 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        zr = z4;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (z8 !== 16'h0000) begin errors++; $display("FAIL reset_z got %h want 0000", z8); end
        checks++; if (z4 !== 8'h00 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_w4 got z=%h busy=%b want 00/0", z4, busy4); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        logic [15:0] zr;
        int lat, bc;
        do_op8(1'b0, 8'hFF, 8'hFF, zr, lat, bc);
        checks++; if (zr !== 16'hFE01) begin errors++; $display("FAIL unsigned_ff got %h want fe01", zr); end
        // done visible after edge E0+9, i.e. in the 10th cycle counting from the start edge
        checks++; if (lat !== 9) begin errors++; $display("FAIL unsigned_latency got %0d want 9", lat); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL unsigned_busy_cycles got %0d want 9", bc); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done8); end
    endtask

    task automatic test_signed;
        logic [7:0]  ta [4] = '{8'h80, 8'hFD, 8'h7F, 8'h00};
        logic [7:0]  tb [4] = '{8'h80, 8'h07, 8'h7F, 8'h80};
        logic [15:0] te [4] = '{16'h4000, 16'hFFEB, 16'h3F01, 16'h0000};
        logic [15:0] zr;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op8(1'b1, ta[i], tb[i], zr, lat, bc);
            checks++;
            if (zr !== te[i] || lat !== 9) begin
                errors++;
                $display("FAIL signed_%0d got z=%h lat=%0d want z=%h lat=9", i, zr, lat, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int last, ndone, tail;
        last = -1; ndone = 0; tail = 0;
        @(negedge clk);
        start8 = 1'b1; x8 = 8'd3; y8 = 8'd3; sm8 = 1'b0;
        for (int e = 0; e < 35; e++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                checks++; if (z8 !== 16'h0009) begin errors++; $display("FAIL b2b_z got %h want 0009", z8); end
                checks++;
                if ((last < 0 && e != 9) || (last >= 0 && e - last != 10)) begin
                    errors++; $display("FAIL b2b_spacing got edge %0d after %0d want period 10 from 9", e, last);
                end
                last = e;
            end
        end
        start8 = 1'b0;
        // One operation was accepted just before start dropped; it must finish once.
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done8) tail++;
        end
        checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", ndone); end
        checks++; if (tail !== 1) begin errors++; $display("FAIL b2b_tail got %0d want 1", tail); end
    endtask

    task automatic test_hold;
        int nd = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk); #1;
            if (done8) nd++;
        end
        checks++; if (z8 !== 16'h0009 || nd !== 0) begin errors++; $display("FAIL hold got z=%h dones=%0d want 0009/0", z8, nd); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] zr;
        int lat, bc, nd;
        nd = 0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'h12; y8 = 8'h34;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy8); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || z8 !== 16'h0000) begin
            errors++; $display("FAIL midrst_async got busy=%b done=%b z=%h want 0/0/0000", busy8, done8, z8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done8 || busy8) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", nd); end
        do_op8(1'b0, 8'd6, 8'd2, zr, lat, bc);
        checks++; if (zr !== 16'h000C || lat !== 9) begin errors++; $display("FAIL midrst_after got z=%h lat=%0d want 000c/9", zr, lat); end
    endtask

    task automatic test_random;
        logic [15:0] zr;
        logic [7:0]  a, b;
        logic        sm;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            do_op8(sm, a, b, zr, lat, bc);
            checks++;
            if (zr !== 16'(ref_mul(8, sm, longint'(a), longint'(b))) || lat !== 9) begin
                errors++;
                $display("FAIL random sm=%b %h*%h got z=%h lat=%0d want z=%h lat=9", sm, a, b, zr, lat,
                         16'(ref_mul(8, sm, longint'(a), longint'(b))));
            end
        end
    endtask

    task automatic test_exhaustive4;
        logic [7:0] zr;
        logic [3:0] a, b;
        int lat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    a = 4'(i); b = 4'(j);
                    do_op4(1'(s), a, b, zr, lat);
                    checks++;
                    if (zr !== 8'(ref_mul(4, 1'(s), longint'(a), longint'(b))) || lat !== 5) begin
                        errors++;
                        $display("FAIL exh4 sm=%0d %h*%h got z=%h lat=%0d want z=%h lat=5", s, a, b, zr, lat,
                                 8'(ref_mul(4, 1'(s), longint'(a), longint'(b))));
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
        start4 = 1'b0; sm4 = 1'b0; x4 = '0; y4 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        test_exhaustive4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_array_multiplier.md
Name: seq_array_multiplier

Overview:
- Parametrised sequential shift-add multiplier. It is the next generation of the team's fixed 4x4 combinational array multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement signed (selected per operation), over WIDTH iterations.
- Uses a start/busy/done handshake and holds the 2*WIDTH-bit product until the next operation.
- Sits between register-file/switch inputs and the display/ALU result bus in lab datapaths.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- x  input  WIDTH  multiplicand; sampled with start.
- y  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product valid.
- z  output  2*WIDTH  product; held stable until the next accepted start completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0; done=0; z=0; internal accumulator, shift registers and counter cleared.
  - Reset mid-operation aborts it: no done pulse, z=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 accepts the operation.
  - Latches |x| and |y| (magnitudes when signed_mode=1 and the MSB is set, otherwise raw values).
  - Latches neg = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]).
  - Clears accumulator and counter; busy<=1; next state RUN.
- RUN, each cycle:
  - If the multiplier LSB=1, add the multiplicand into the upper WIDTH+1 accumulator bits.
  - Shift the {carry, accumulator, multiplier} right by 1; counter++.
  - After WIDTH iterations, go to FIX.
- FIX, one cycle:
  - z <= neg ? two's-complement negate of the 2*WIDTH magnitude : magnitude.
  - done<=1 for that edge only; busy<=0; next state IDLE.
- Latency: done high and z valid in the cycle after edge E0+WIDTH+1. A new start may be accepted in the done cycle, giving back-to-back throughput of one result per WIDTH+2 cycles.
- start while busy=1: ignored, no queuing. x, y and signed_mode may change freely during busy without affecting the result.
- z is updated only in FIX. Between operations z holds the last product; done is the only validity indicator.
- Width rules:
  - Magnitude of the most negative operand (-2^(WIDTH-1)) is representable in WIDTH unsigned bits. No overflow is possible.
  - Signed products always fit in 2*WIDTH bits, e.g. (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- Zero operand: full WIDTH iterations still run. Result 0 with neg ignored (negating 0 yields 0).
- signed_mode=0: MSBs are treated as magnitude bits; neg=0.

Decomposition:
- Shared package mult_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, FIX=2'd2).
  - Default WIDTH constant.
  - The function for conditional two's-complement negate, reused for operand abs and product fix.
- One natural sub-module, mult_datapath:
  - Holds the accumulator, multiplier shift register, carry and adder.
  - Controlled by load/step inputs from the top-level FSM.
  - The FSM and counter stay in seq_array_multiplier.

Test Plan (WIDTH=8 unless noted):
- Unsigned: x=0xFF, y=0xFF, signed_mode=0, start pulse -> done exactly 10 cycles after the start edge, z=0xFE01, busy high 9 cycles.
- Signed: x=0x80 (-128), y=0x80 (-128), signed_mode=1 -> z=0x4000. Second case: x=0xFD (-3), y=0x07 -> z=0xFFEB (-21).
- Handshake:
  - start held high continuously with x=3, y=3 -> results 0x0009 at every 10th cycle.
  - Toggling x during busy does not change z.
  - No extra done pulses.
- Reset mid-operation: assert rst_n=0 five cycles into x=0x12, y=0x34 -> busy, done and z go 0 immediately (asynchronous, before the next clock edge). After release, x=6, y=2 -> z=0x000C.
- Zero/boundary: x=0, y=0x80 signed -> z=0x0000. x=0x7F, y=0x7F signed -> z=0x3F01.
- Exhaustive check: WIDTH=4 build, all 256 operand pairs in both modes against a reference model. Includes 15*15=225 unsigned and (-8)*(-8)=64 signed.
